// File: rtl/sdith_params_pkg.sv
// Shared SDitH parameters for the sign-path blocks: the CLOG2 helper macro,
// the GF widths, the per-parameter-set M/K/T tables and the Horner FSM
// state encodings.
`ifndef SDITH_PARAMS_PKG_SV
`define SDITH_PARAMS_PKG_SV

`define CLOG2(x) $clog2(x)

package sdith_params;

    localparam int GF32_W = 32;
    localparam int GF_W   = 8;

    // Reduction polynomial x^32 + x^7 + x^3 + x^2 + 1 (the x^32 term is implicit)
    localparam logic [GF32_W-1:0] GF32_POLY = 32'h0000_008D;

    // Per-set code length M, dimension K and number of evaluation points T
    localparam int M_L1 = 230;
    localparam int M_L3 = 352;
    localparam int M_L5 = 480;
    localparam int K_L1 = 126;
    localparam int K_L3 = 193;
    localparam int K_L5 = 278;
    localparam int T_L1 = 3;
    localparam int T_L3 = 3;
    localparam int T_L5 = 4;

    // Horner evaluator state encodings
    localparam logic [3:0] ST_IDLE  = 4'd0;
    localparam logic [3:0] ST_RD    = 4'd1;
    localparam logic [3:0] ST_LATCH = 4'd2;
    localparam logic [3:0] ST_MUL   = 4'd3;
    localparam logic [3:0] ST_MWAIT = 4'd4;
    localparam logic [3:0] ST_DONE  = 4'd5;

    typedef enum logic [3:0] {
        S_IDLE  = ST_IDLE,
        S_RD    = ST_RD,
        S_LATCH = ST_LATCH,
        S_MUL   = ST_MUL,
        S_MWAIT = ST_MWAIT,
        S_DONE  = ST_DONE
    } poly_state_t;

    // Parameter-set lookups; the set name is a two-character string ("L1", "L3", "L5")
    function automatic int set_m(input logic [15:0] set_name);
        if (set_name == "L5") return M_L5;
        if (set_name == "L3") return M_L3;
        return M_L1;
    endfunction

    function automatic int set_k(input logic [15:0] set_name);
        if (set_name == "L5") return K_L5;
        if (set_name == "L3") return K_L3;
        return K_L1;
    endfunction

    function automatic int set_t(input logic [15:0] set_name);
        if (set_name == "L5") return T_L5;
        if (set_name == "L3") return T_L3;
        return T_L1;
    endfunction

endpackage

`endif

// File: rtl/gf32_mul_hs.sv
// Bit-serial GF(2^32) multiplier with a start/done handshake. One operand
// bit is consumed per cycle, MSB first, so the product is ready 32 cycles
// after start; o_p is held until the next start.
module gf32_mul_hs
    import sdith_params::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [GF32_W-1:0] i_x,
    input  logic [GF32_W-1:0] i_y,
    output logic [GF32_W-1:0] o_p,
    output logic              o_done
);

    logic              busy;
    logic [4:0]        bit_cnt;
    logic [GF32_W-1:0] x_reg;
    logic [GF32_W-1:0] y_reg;
    logic [GF32_W-1:0] p_next;

    // One shift-and-add step: double the partial product, reduce, add x if the current y bit is set
    always_comb begin
        p_next = {o_p[GF32_W-2:0], 1'b0} ^ (o_p[GF32_W-1] ? GF32_POLY : '0);
        if (y_reg[GF32_W-1]) begin
            p_next = p_next ^ x_reg;
        end
    end

    // Operand capture on start, then 32 iterations and a single done pulse
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            busy    <= 1'b0;
            bit_cnt <= '0;
            x_reg   <= '0;
            y_reg   <= '0;
            o_p     <= '0;
            o_done  <= 1'b0;
        end else begin
            o_done <= 1'b0;
            if (!busy) begin
                if (i_start) begin
                    busy    <= 1'b1;
                    bit_cnt <= '0;
                    x_reg   <= i_x;
                    y_reg   <= i_y;
                    o_p     <= '0;
                end
            end else begin
                o_p     <= p_next;
                y_reg   <= {y_reg[GF32_W-2:0], 1'b0};
                bit_cnt <= bit_cnt + 5'd1;
                if (bit_cnt == 5'd31) begin
                    busy   <= 1'b0;
                    o_done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/poly_eval_horner.sv
// Horner evaluator for the sign path: reads N_COEF GF256 coefficients from
// the highest index down and evaluates the polynomial at T points of
// GF(2^32) using a start/done multiplier.
// Build option: POLY_EVAL_INTERNAL_MUL_EN instantiates gf32_mul_hs inside
// this block and ties the external multiplier request ports to zero;
// without it the external multiplier ports are used.
module poly_eval_horner
    import sdith_params::*;
#(
    parameter logic [15:0] PARAMETER_SET = "L1",
    parameter int          N_COEF        = set_m(PARAMETER_SET),
    parameter int          T             = set_t(PARAMETER_SET),
    parameter int          AW            = (N_COEF > 1) ? `CLOG2(N_COEF) : 1
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_start,
    input  logic [32*T-1:0]     i_r,
    output logic [AW-1:0]       o_coef_addr,
    output logic                o_coef_rd,
    input  logic [7:0]          i_coef,
    output logic [32*T-1:0]     o_eval,
    output logic                o_done,
    output logic                o_start_mul32,
    output logic [31:0]         o_x_mul32,
    output logic [31:0]         o_y_mul32,
    input  logic [31:0]         i_o_mul32,
    input  logic                i_done_mul32
);

    localparam int TW = (T > 1) ? `CLOG2(T) : 1;

    poly_state_t       state;
    poly_state_t       state_nxt;

    logic [GF32_W-1:0] r_reg [T];
    logic [GF32_W-1:0] acc   [T];
    logic [AW-1:0]     idx;
    logic [TW-1:0]     t_idx;
    logic [GF_W-1:0]   coef_reg;

    logic              mul_start;
    logic [GF32_W-1:0] mul_x;
    logic [GF32_W-1:0] mul_y;
    logic [GF32_W-1:0] mul_p;
    logic              mul_done;

    logic              last_point;
    logic              last_coef;

    assign last_point  = (int'(t_idx) == T - 1);
    assign last_coef   = (idx == '0);
    assign o_coef_addr = idx;

    // Operands come straight from the registers; they cannot change while the multiply is in flight
    assign mul_x = acc[t_idx];
    assign mul_y = r_reg[t_idx];

`ifdef POLY_EVAL_INTERNAL_MUL_EN
    logic unused_ext_mul;

    assign unused_ext_mul = ^{i_o_mul32, i_done_mul32};
    assign o_start_mul32  = 1'b0;
    assign o_x_mul32      = '0;
    assign o_y_mul32      = '0;

    gf32_mul_hs u_mul (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_start (mul_start),
        .i_x     (mul_x),
        .i_y     (mul_y),
        .o_p     (mul_p),
        .o_done  (mul_done)
    );
`else
    assign o_start_mul32 = mul_start;
    assign o_x_mul32     = mul_x;
    assign o_y_mul32     = mul_y;
    assign mul_p         = i_o_mul32;
    assign mul_done      = i_done_mul32;
`endif

    // State register; reset aborts any run in progress
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and strobe decode: read one coefficient, then one multiply per point
    always_comb begin
        state_nxt = state;
        mul_start = 1'b0;
        o_coef_rd = 1'b0;
        case (state)
            S_IDLE: begin
                if (i_start) begin
                    state_nxt = S_RD;
                end
            end
            S_RD: begin
                o_coef_rd = 1'b1;
                state_nxt = S_LATCH;
            end
            S_LATCH: begin
                state_nxt = S_MUL;
            end
            S_MUL: begin
                mul_start = 1'b1;
                state_nxt = S_MWAIT;
            end
            S_MWAIT: begin
                if (mul_done) begin
                    if (!last_point) begin
                        state_nxt = S_MUL;
                    end else if (!last_coef) begin
                        state_nxt = S_RD;
                    end else begin
                        state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Datapath: latch points, step the accumulators acc = acc*r ^ c, publish results with a done pulse
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            idx      <= '0;
            t_idx    <= '0;
            coef_reg <= '0;
            o_done   <= 1'b0;
            o_eval   <= '0;
            for (int k = 0; k < T; k++) begin
                r_reg[k] <= '0;
                acc[k]   <= '0;
            end
        end else begin
            o_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        idx <= AW'(N_COEF - 1);
                        for (int k = 0; k < T; k++) begin
                            r_reg[k] <= i_r[GF32_W*k +: GF32_W];
                            acc[k]   <= '0;
                        end
                    end
                end
                S_LATCH: begin
                    coef_reg <= i_coef;
                    t_idx    <= '0;
                end
                S_MWAIT: begin
                    if (mul_done) begin
                        acc[t_idx] <= mul_p ^ {{(GF32_W-GF_W){1'b0}}, coef_reg};
                        if (!last_point) begin
                            t_idx <= t_idx + TW'(1);
                        end else if (!last_coef) begin
                            idx <= idx - AW'(1);
                        end
                    end
                end
                S_DONE: begin
                    o_done <= 1'b1;
                    for (int k = 0; k < T; k++) begin
                        o_eval[GF32_W*k +: GF32_W] <= acc[k];
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_poly_eval_horner.sv
// Scoreboard bench for poly_eval_horner: stimulus pushes the expected results
// (power-sum reference model), the expected latency and the start cycle; a
// monitor checks them whenever o_done pulses. Coefficient memory and the GF32
// multiplier with configurable latency are modelled here.
module tb_poly_eval_horner;

    localparam int N  = 3;
    localparam int T  = 3;
    localparam int AW = 2;

    typedef logic [7:0] coef_arr_t [N];

    logic              i_clk = 1'b0;
    logic              i_rst = 1'b1;
    logic              i_start = 1'b0;
    logic [32*T-1:0]   i_r = '0;
    logic [AW-1:0]     o_coef_addr;
    logic              o_coef_rd;
    logic [7:0]        i_coef = 8'h00;
    logic [32*T-1:0]   o_eval;
    logic              o_done;
    logic              o_start_mul32;
    logic [31:0]       o_x_mul32;
    logic [31:0]       o_y_mul32;
    logic [31:0]       i_o_mul32;
    logic              i_done_mul32;

    int n_tests   = 0;
    int n_fail    = 0;
    int cyc       = 0;
    int done_seen = 0;

    coef_arr_t       coef_mem = '{8'h00, 8'h00, 8'h00};
    int              mul_lat  = 1;
    int              mul_cnt  = 0;
    logic [31:0]     mul_prod = '0;

    logic [32*T-1:0] exp_q   [$];
    int              lat_q   [$];
    int              start_q [$];
    int              rd_q    [$];

    poly_eval_horner #(
        .PARAMETER_SET ("L1"),
        .N_COEF        (N),
        .T             (T),
        .AW            (AW)
    ) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_start       (i_start),
        .i_r           (i_r),
        .o_coef_addr   (o_coef_addr),
        .o_coef_rd     (o_coef_rd),
        .i_coef        (i_coef),
        .o_eval        (o_eval),
        .o_done        (o_done),
        .o_start_mul32 (o_start_mul32),
        .o_x_mul32     (o_x_mul32),
        .o_y_mul32     (o_y_mul32),
        .i_o_mul32     (i_o_mul32),
        .i_done_mul32  (i_done_mul32)
    );

    always #5 i_clk = ~i_clk;

    // Cycle counter used for latency measurement
    always @(posedge i_clk) cyc <= cyc + 1;

    // GF(2^32) product mod x^32+x^7+x^3+x^2+1, LSB-first shift-and-add
    function automatic logic [31:0] gfMul(input logic [31:0] a_in, input logic [31:0] b);
        logic [31:0] a;
        logic [31:0] p;
        a = a_in;
        p = '0;
        for (int i = 0; i < 32; i++) begin
            if (b[i]) p = p ^ a;
            a = {a[30:0], 1'b0} ^ (a[31] ? 32'h0000_008D : 32'h0);
        end
        return p;
    endfunction

    // Reference: sum over i of c_i * r^i, with r^0 = 1
    function automatic logic [31:0] evalPoint(input coef_arr_t c, input logic [31:0] r);
        logic [31:0] sum;
        logic [31:0] pw;
        sum = '0;
        pw  = 32'h1;
        for (int i = 0; i < N; i++) begin
            sum = sum ^ gfMul({24'h0, c[i]}, pw);
            pw  = gfMul(pw, r);
        end
        return sum;
    endfunction

    // Coefficient memory: one-cycle read latency
    always @(posedge i_clk) begin
        if (o_coef_rd) i_coef <= coef_mem[o_coef_addr];
    end

    // External multiplier with programmable latency mul_lat
    always @(posedge i_clk) begin
        if (o_start_mul32) begin
            mul_prod <= gfMul(o_x_mul32, o_y_mul32);
            mul_cnt  <= mul_lat;
        end else if (mul_cnt > 0) begin
            mul_cnt <= mul_cnt - 1;
        end
    end
    assign i_done_mul32 = (mul_cnt == 1);
    assign i_o_mul32    = mul_prod;

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endtask

    // Record every coefficient read address
    always @(negedge i_clk) begin
        if (!i_rst && o_coef_rd) rd_q.push_back(int'(o_coef_addr));
    end

    // Monitor: on each done pulse pop the scoreboard and compare results, latency and read order
    always @(negedge i_clk) begin
        if (!i_rst && o_done) begin
            done_seen++;
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("[TB] FAIL unexpected_done: got o_done=1 at cycle %0d, expected no pending run", cyc);
            end else begin
                logic [32*T-1:0] e;
                int              l;
                int              s;
                e = exp_q.pop_front();
                l = lat_q.pop_front();
                s = start_q.pop_front();
                for (int t = 0; t < T; t++) begin
                    checkOutput($sformatf("eval_word%0d", t), 128'(o_eval[32*t +: 32]), 128'(e[32*t +: 32]));
                end
                checkOutput("latency", 128'(cyc - s), 128'(l));
                checkOutput("read_count", 128'(rd_q.size()), 128'(N));
                for (int i = 0; i < rd_q.size() && i < N; i++) begin
                    checkOutput($sformatf("read_addr%0d", i), 128'(rd_q[i]), 128'(N - 1 - i));
                end
            end
            rd_q.delete();
        end
    end

    // Issue one evaluation, push its expectations and wait (bounded) for done
    task automatic applyStimulus(input coef_arr_t c, input logic [32*T-1:0] r, input int lat, input bit mid_start);
        logic [32*T-1:0] e;
        int              target;
        @(negedge i_clk);
        coef_mem = c;
        mul_lat  = lat;
        for (int t = 0; t < T; t++) e[32*t +: 32] = evalPoint(c, r[32*t +: 32]);
        exp_q.push_back(e);
        lat_q.push_back(2 + N * (2 + T * (lat + 1)));
        start_q.push_back(cyc);
        target  = done_seen + 1;
        i_r     = r;
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        if (mid_start) begin
            repeat (5) @(negedge i_clk);
            i_r     = ~r;
            i_start = 1'b1;
            @(negedge i_clk);
            i_start = 1'b0;
        end
        for (int k = 0; k < 3000 && done_seen < target; k++) @(negedge i_clk);
        if (done_seen < target) begin
            n_tests++;
            n_fail++;
            $display("[TB] FAIL done_timeout: got no o_done, expected one within 3000 cycles");
            exp_q.delete();
            lat_q.delete();
            start_q.delete();
        end else begin
            repeat (3) @(negedge i_clk);
            checkOutput("eval_held", 128'(o_eval), 128'(e));
            checkOutput("done_one_cycle", 128'(o_done), 128'(0));
        end
    endtask

    initial begin
        coef_arr_t       c;
        logic [32*T-1:0] r;
        logic [31:0]     w;

        // Reset state
        i_rst = 1'b1;
        repeat (3) @(negedge i_clk);
        checkOutput("rst_eval", 128'(o_eval), 128'(0));
        checkOutput("rst_done", 128'(o_done), 128'(0));
        checkOutput("rst_coef_rd", 128'(o_coef_rd), 128'(0));
        checkOutput("rst_coef_addr", 128'(o_coef_addr), 128'(0));
        checkOutput("rst_start_mul", 128'(o_start_mul32), 128'(0));
        i_rst = 1'b0;

        // Constant coefficient survives any point
        c = '{8'h01, 8'h00, 8'h00};
        r = {$urandom, $urandom, 32'h1234_5678};
        applyStimulus(c, r, 1, 1'b0);

        // Linear term at r=2
        c = '{8'h00, 8'h01, 8'h00};
        r = {$urandom, $urandom, 32'h0000_0002};
        applyStimulus(c, r, 2, 1'b0);

        // 1 + x + x^2 at r = 1, 0, 2, with short and long multiplier latency
        c = '{8'h01, 8'h01, 8'h01};
        r = {32'h2, 32'h0, 32'h1};
        applyStimulus(c, r, 1, 1'b0);
        applyStimulus(c, r, 5, 1'b0);

        // A second start during the run must be ignored
        applyStimulus(c, r, 3, 1'b1);

        // Reset mid-run with a multiply pending
        @(negedge i_clk);
        coef_mem = '{8'hA5, 8'h3C, 8'h7E};
        mul_lat  = 5;
        i_r      = {$urandom, $urandom, $urandom};
        i_start  = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        repeat (6) @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);
        checkOutput("midrst_done", 128'(o_done), 128'(0));
        checkOutput("midrst_coef_rd", 128'(o_coef_rd), 128'(0));
        checkOutput("midrst_eval", 128'(o_eval), 128'(0));
        i_rst = 1'b0;
        rd_q.delete();
        repeat (10) @(negedge i_clk);
        c = '{8'h01, 8'h01, 8'h01};
        r = {32'h2, 32'h0, 32'h1};
        applyStimulus(c, r, 1, 1'b0);

        // Randomized runs covering zero polynomial, r=0 and equal points
        for (int n = 0; n < 8; n++) begin
            for (int i = 0; i < N; i++) c[i] = 8'($urandom);
            r = {$urandom, $urandom, $urandom};
            case (n % 4)
                0: c = '{8'h00, 8'h00, 8'h00};
                1: r[31:0] = 32'h0;
                2: begin
                    w = $urandom;
                    r = {w, w, w};
                end
                default: begin
                end
            endcase
            applyStimulus(c, r, int'($urandom_range(1, 5)), 1'b0);
        end

        repeat (5) @(negedge i_clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
